// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: FSM state encodings,
// opcode/decoder-key constants, aluop codes 1..37 and instruction class ranges.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } seq_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] F7_ALT     = 7'h20;

  // Decoder key = {funct7, funct3, opcode}
  localparam logic [16:0] KEY_ADD   = {7'h00, 3'b000, OPC_OP};
  localparam logic [16:0] KEY_SUB   = {F7_ALT, 3'b000, OPC_OP};
  localparam logic [16:0] KEY_ADDI  = {7'h00, 3'b000, OPC_OPIMM};
  localparam logic [16:0] KEY_SRAI  = {F7_ALT, 3'b101, OPC_OPIMM};
  localparam logic [16:0] KEY_LW    = {7'h00, 3'b010, OPC_LOAD};
  localparam logic [16:0] KEY_SW    = {7'h00, 3'b010, OPC_STORE};
  localparam logic [16:0] KEY_BEQ   = {7'h00, 3'b000, OPC_BRANCH};
  localparam logic [16:0] KEY_JALR  = {7'h00, 3'b000, OPC_JALR};
  localparam logic [16:0] KEY_JAL   = {7'h00, 3'b000, OPC_JAL};
  localparam logic [16:0] KEY_LUI   = {7'h00, 3'b000, OPC_LUI};
  localparam logic [16:0] KEY_AUIPC = {7'h00, 3'b000, OPC_AUIPC};

  localparam logic [5:0] ALU_ADD  = 6'd1,  ALU_SUB  = 6'd2,  ALU_SLL  = 6'd3,  ALU_SLT   = 6'd4;
  localparam logic [5:0] ALU_SLTU = 6'd5,  ALU_XOR  = 6'd6,  ALU_SRL  = 6'd7,  ALU_SRA   = 6'd8;
  localparam logic [5:0] ALU_OR   = 6'd9,  ALU_AND  = 6'd10, ALU_ADDI = 6'd11, ALU_SLTI  = 6'd12;
  localparam logic [5:0] ALU_SLTIU= 6'd13, ALU_XORI = 6'd14, ALU_ORI  = 6'd15, ALU_ANDI  = 6'd16;
  localparam logic [5:0] ALU_SLLI = 6'd17, ALU_SRLI = 6'd18, ALU_SRAI = 6'd19, ALU_LB    = 6'd20;
  localparam logic [5:0] ALU_LH   = 6'd21, ALU_LW   = 6'd22, ALU_LBU  = 6'd23, ALU_LHU   = 6'd24;
  localparam logic [5:0] ALU_JALR = 6'd25, ALU_SB   = 6'd26, ALU_SH   = 6'd27, ALU_SW    = 6'd28;
  localparam logic [5:0] ALU_BEQ  = 6'd29, ALU_BNE  = 6'd30, ALU_BLT  = 6'd31, ALU_BGE   = 6'd32;
  localparam logic [5:0] ALU_BLTU = 6'd33, ALU_BGEU = 6'd34, ALU_LUI  = 6'd35, ALU_AUIPC = 6'd36;
  localparam logic [5:0] ALU_JAL  = 6'd37;

  // Class ranges over aluop
  localparam logic [5:0] CLS_ALU_LO    = ALU_ADD,  CLS_ALU_HI    = ALU_SRAI;
  localparam logic [5:0] CLS_LOAD_LO   = ALU_LB,   CLS_LOAD_HI   = ALU_LHU;
  localparam logic [5:0] CLS_STORE_LO  = ALU_SB,   CLS_STORE_HI  = ALU_SW;
  localparam logic [5:0] CLS_BRANCH_LO = ALU_BEQ,  CLS_BRANCH_HI = ALU_BGEU;
  localparam logic [5:0] CLS_UPPER_LO  = ALU_LUI,  CLS_UPPER_HI  = ALU_AUIPC;
  localparam logic [5:0] CLS_WR_LO     = ALU_ADDI, CLS_WR_HI     = ALU_JALR;

  function automatic logic in_range(input logic [5:0] v, input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rv_seq_classify.sv
// Combinational instruction classifier: builds the 17-bit decoder key from the
// IR fields and derives legality and instruction class from the encoding alone.
module rv_seq_classify
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [6:0]  opcode,
  output logic [16:0] opcodes,
  output logic        legal,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        writes_rd
);

  logic [6:0] key_f7;
  logic [2:0] key_f3;

  always_comb begin
    key_f7    = 7'd0;
    key_f3    = funct3;
    legal     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        key_f7    = funct7;
        legal     = (funct7 == 7'h00) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        writes_rd = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the shift-immediates carry a meaningful funct7
        if (funct3 == 3'b001) begin
          key_f7 = funct7;
          legal  = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
          key_f7 = funct7;
          legal  = (funct7 == 7'h00) || (funct7 == F7_ALT);
        end else begin
          legal  = 1'b1;
        end
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        legal     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        legal    = funct3 inside {3'b000, 3'b001, 3'b010};
        is_store = 1'b1;
      end
      OPC_BRANCH: begin
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        is_branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        key_f3    = 3'b000;
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        key_f3    = 3'b000;
        legal     = 1'b1;
        is_jump   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        legal     = (funct3 == 3'b000);
        is_jump   = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign opcodes = {key_f7, key_f3, opcode};

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle RV32I sequencer FSM owning PC and IR; optional performance counters
// (cycle_cnt, instret_cnt) are built when RV_SEQ_PERF_CNT_EN is defined.
module rv_multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [16:0] opcodes,
  input  logic [5:0]  aluop,
  input  logic        werf,
  input  logic        take,
  input  logic [31:0] target_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap
`ifdef RV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] wait_q, wait_d;
  logic        legal, is_load, is_store, is_branch, is_jump, writes_rd;
  logic        timeout_hit;
  logic [31:0] pc_plus4;

  rv_seq_classify u_classify (
    .funct7    (ir_q[31:25]),
    .funct3    (ir_q[14:12]),
    .opcode    (ir_q[6:0]),
    .opcodes   (opcodes),
    .legal     (legal),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .writes_rd (writes_rd)
  );

  assign pc_plus4    = pc_q + 32'd4;
  assign timeout_hit = (MEM_WAIT_MAX != 0) && ((wait_q + 32'd1) == 32'(MEM_WAIT_MAX));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    tgt_d    = tgt_q;
    wait_d   = wait_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          wait_d  = 32'd0;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 32'd1;
          if (timeout_hit) state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        // target_pc is only guaranteed here, so keep it for a jump's WB
        tgt_d = target_pc;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_d    = take ? target_pc : pc_plus4;
          state_d = S_FETCH;
        end else if (writes_rd) begin
          state_d = S_WB;
        end else begin
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = in_range(aluop, CLS_STORE_LO, CLS_STORE_HI);
        if (dmem_ack) begin
          wait_d = 32'd0;
          if (is_store) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_q + 32'd1;
          if (timeout_hit) state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = werf || in_range(aluop, CLS_WR_LO, CLS_WR_HI) ||
                  in_range(aluop, CLS_UPPER_LO, ALU_JAL);
        pc_d    = is_jump ? tgt_q : pc_plus4;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
    // No request or strobe escapes while reset is asserted
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      tgt_q   <= 32'd0;
      wait_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
      wait_q  <= wait_d;
    end
  end

`ifdef RV_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if ((state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB}))
      instret_cnt_d = instret_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign state     = state_q;
  assign trap      = (state_q == S_TRAP);

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Directed bench for rv_multicycle_sequencer: a table of instructions with
// hand-computed key/latency/strobe/PC results, plus reset, trap and timeout cases.
module tb_rv_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [16:0] opcodes;
  logic [5:0]  aluop;
  logic        werf;
  logic        take;
  logic [31:0] target_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        trap;
`ifdef RV_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_multicycle_sequencer #(
    .RESET_PC     (32'h0000_0000),
    .MEM_WAIT_MAX (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcodes     (opcodes),
    .aluop       (aluop),
    .werf        (werf),
    .take        (take),
    .target_pc   (target_pc),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .pc          (pc),
    .state       (state),
    .trap        (trap)
`ifdef RV_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] word;
    logic [5:0]  aluop;
    logic        werf;
    logic        take;
    logic [31:0] tgt;
    int          waits;
    logic [16:0] key;
    int          cycles;
    int          rf;
    int          dreq;
    logic        we;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays memory for one instruction from FETCH until FETCH or TRAP again.
  // Acks are asserted even when no request is pending; they must be ignored.
  task automatic run_instr(input vec_t v, output int cyc, output int rfc, output int drq,
                           output logic we, output logic both, output logic [16:0] key);
    int mw;
    mw = 0; cyc = 0; rfc = 0; drq = 0; we = 1'b0; both = 1'b0; key = '0;
    aluop = v.aluop; werf = v.werf; take = v.take; target_pc = v.tgt; imem_rdata = v.word;
    do begin
      @(negedge clk);
      cyc++;
      if (state == 3'd1) key = opcodes;
      if (rf_we) rfc++;
      if (dmem_req) begin
        drq++;
        we = we | dmem_we;
      end
      if (rf_we && dmem_req) both = 1'b1;
      imem_ack = 1'b1;
      dmem_ack = !dmem_req || (mw == v.waits);
      if (dmem_req && !dmem_ack) mw++;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
    end while (state != 3'd0 && state != 3'd5 && cyc < 40);
  endtask

  task automatic apply_vec(input vec_t v, input int idx, input logic [31:0] start_pc);
    int cyc, rfc, drq;
    logic we, both;
    logic [16:0] key;
    check($sformatf("v%0d_fetch_addr", idx), imem_addr, start_pc);
    run_instr(v, cyc, rfc, drq, we, both, key);
    check($sformatf("v%0d_key", idx), 32'(key), 32'(v.key));
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.cycles));
    check($sformatf("v%0d_rf_we_pulses", idx), 32'(rfc), 32'(v.rf));
    check($sformatf("v%0d_dmem_req_cycles", idx), 32'(drq), 32'(v.dreq));
    check($sformatf("v%0d_dmem_we", idx), 32'(we), 32'(v.we));
    check($sformatf("v%0d_rf_and_dmem", idx), 32'(both), 32'd0);
    check($sformatf("v%0d_state", idx), 32'(state), 32'd0);
    check($sformatf("v%0d_pc", idx), pc, v.pc);
    $display("vec %0d: word=%h key=%h cycles=%0d rf_we=%0d dmem=%0d pc=%h",
             idx, v.word, key, cyc, rfc, drq, pc);
  endtask

  initial begin
    int   fetch_cycles;
    int   bad;
    logic trapped;
    int   cyc, rfc, drq;
    logic we, both;
    logic [16:0] key;
    logic [31:0] exp_pc;
    vec_t v;

    //        word          aluop  werf take  tgt            w  key        cyc rf dq we    pc
    vecs[0]  = '{32'h003100B3, 6'd1,  1'b1, 1'b0, 32'h0000_0000, 0, 17'h00033, 4, 1, 0, 1'b0, 32'h0000_0004};
    vecs[1]  = '{32'h403100B3, 6'd2,  1'b1, 1'b0, 32'h0000_0000, 0, 17'h08033, 4, 1, 0, 1'b0, 32'h0000_0008};
    vecs[2]  = '{32'h00510093, 6'd11, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00013, 4, 1, 0, 1'b0, 32'h0000_000C};
    vecs[3]  = '{32'h40315093, 6'd19, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h08293, 4, 1, 0, 1'b0, 32'h0000_0010};
    vecs[4]  = '{32'hFFF00093, 6'd11, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00013, 4, 1, 0, 1'b0, 32'h0000_0014};
    vecs[5]  = '{32'h123450B7, 6'd35, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00037, 4, 1, 0, 1'b0, 32'h0000_0018};
    vecs[6]  = '{32'h0000A083, 6'd22, 1'b0, 1'b0, 32'h0000_0000, 3, 17'h00103, 8, 1, 4, 1'b0, 32'h0000_001C};
    vecs[7]  = '{32'h00112023, 6'd28, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00123, 4, 0, 1, 1'b1, 32'h0000_0020};
    vecs[8]  = '{32'h00000063, 6'd29, 1'b0, 1'b1, 32'h0000_0100, 0, 17'h00063, 3, 0, 0, 1'b0, 32'h0000_0100};
    vecs[9]  = '{32'h00001063, 6'd30, 1'b0, 1'b0, 32'h0000_0500, 0, 17'h000E3, 3, 0, 0, 1'b0, 32'h0000_0104};
    vecs[10] = '{32'h000000EF, 6'd37, 1'b0, 1'b0, 32'h0000_0200, 0, 17'h0006F, 4, 1, 0, 1'b0, 32'h0000_0200};
    vecs[11] = '{32'h000100E7, 6'd25, 1'b0, 1'b0, 32'h0000_0344, 0, 17'h00067, 4, 1, 0, 1'b0, 32'h0000_0344};
    vecs[12] = '{32'h00001097, 6'd36, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00017, 4, 1, 0, 1'b0, 32'h0000_0348};
    vecs[13] = '{32'h0000A083, 6'd22, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00103, 5, 1, 1, 1'b0, 32'h0000_034C};

    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h003100B3; dmem_ack = 1'b0;
    aluop = 6'd0; werf = 1'b0; take = 1'b0; target_pc = 32'h0;

    // Reset held two cycles with imem_ack high: IR must not load
    tick(); tick();
    rst = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_ir", instr, 32'h0);
    check("reset_trap", 32'(trap), 32'd0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_imem_req", 32'(imem_req), 32'd1);
    $display("reset: pc=%h state=%0d instr=%h", pc, state, instr);
    tick();

    exp_pc = 32'h0;
    for (int i = 0; i < 14; i++) begin
      apply_vec(vecs[i], i, exp_pc);
      exp_pc = vecs[i].pc;
    end

    // PC wrap: jal to the last word, then a store steps pc+4 through 2^32
    v = '{32'h000000EF, 6'd37, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 17'h0006F, 4, 1, 0, 1'b0, 32'hFFFF_FFFC};
    apply_vec(v, 14, exp_pc);
    v = '{32'h00112023, 6'd28, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h00123, 4, 0, 1, 1'b1, 32'h0000_0000};
    apply_vec(v, 15, 32'hFFFF_FFFC);

    // Reset while a load waits in MEM, with dmem_ack in the same cycle
    apply_vec(vecs[0], 16, 32'h0);
    imem_rdata = 32'h0000A083; aluop = 6'd22; werf = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("midop_in_mem", 32'(state), 32'd3);
    check("midop_dmem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1; dmem_ack = 1'b1;
    tick();
    rst = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("midop_state", 32'(state), 32'd0);
    check("midop_pc", pc, 32'h0);
    check("midop_rf_we", 32'(rf_we), 32'd0);
    check("midop_dmem_req_off", 32'(dmem_req), 32'd0);
    $display("reset mid-load: state=%0d pc=%h", state, pc);
    tick();

    // Illegal word traps in cycle 3 and stays there despite acks
    v = '{32'hFFFF_FFFF, 6'd0, 1'b0, 1'b0, 32'h0000_0000, 0, 17'h0, 2, 0, 0, 1'b0, 32'h0};
    run_instr(v, cyc, rfc, drq, we, both, key);
    check("illegal_cycles", 32'(cyc), 32'd2);
    check("illegal_state", 32'(state), 32'd5);
    check("illegal_trap", 32'(trap), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      if (!trap || state != 3'd5 || imem_req || dmem_req || rf_we || pc != 32'h0) bad++;
    end
    check("trap_held_50", 32'(bad), 32'd0);
    $display("illegal: trapped after %0d cycles, bad hold cycles=%0d", cyc, bad);
    tick();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("trap_recover_trap", 32'(trap), 32'd0);
    check("trap_recover_state", 32'(state), 32'd0);
    check("trap_recover_req", 32'(imem_req), 32'd1);

    // Fetch timeout: imem_ack withheld
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    fetch_cycles = 0; trapped = 1'b0;
    for (int i = 0; i < 40 && !trapped; i++) begin
      @(negedge clk);
      if (state == 3'd0 && imem_req) fetch_cycles++;
      else if (state == 3'd5) trapped = 1'b1;
    end
    check("timeout_wait_cycles", 32'(fetch_cycles), 32'd16);
    check("timeout_trap", 32'(trap), 32'd1);
    $display("timeout: %0d waiting cycles before trap=%0d", fetch_cycles, trap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
